alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_sched_rr_arb2.sv | 32 +++
 rtl/alu_sched.sv | 142 ++++++++++++++
 tb/tb_alu_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request scheduler.
// Opcode and FSM state enums, widths and fixed result codes.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;

  localparam logic [DATA_W-1:0] ILLEGAL_RESULT = 8'hAC;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_MUL = 4'd2,
    ALU_DIV = 4'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic op_is_divz(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] b
  );
    return (op == ALU_DIV) && (b == '0);
  endfunction

  function automatic logic op_is_legal(
    input logic [OP_W-1:0]   op,
    input logic [DATA_W-1:0] b
  );
    return (op <= ALU_MUL) || ((op == ALU_DIV) && (b != '0));
  endfunction

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// Two-input round-robin arbiter.
// Priority flips to the other input only when a grant is accepted.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  // prio_q = 1 means requester 1 wins a tie.
  logic prio_q;

  // Grant the sole requester, or the prioritised one on a tie.
  always_comb begin
    gnt_o    = '0;
    gnt_o[0] = req_i[0] & (~req_i[1] | ~prio_q);
    gnt_o[1] = req_i[1] & (~req_i[0] | prio_q);
  end

  // Hand priority to the other side after an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (upd_i) begin
      prio_q <= gnt_o[0];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Schedules two requesters onto one shared registered ALU.
// Illegal ops and divide-by-zero are answered without the ALU.
module alu_sched
  import alu_pkg::*;
#(
  parameter logic [DATA_W-1:0] DIVZ_RESULT = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  input  logic              r1_valid,
  output logic              r0_ready,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r0_op,
  input  logic [OP_W-1:0]   r1_op,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_f,
  output logic              rsp_cout,
  output logic              rsp_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_cout
);

  state_e state_q, state_d;

  logic [1:0]        gnt;
  logic              acc;
  logic              acc_id;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              legal;
  logic              divz;

  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [OP_W-1:0]   alu_sel_q;
  logic              id_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_f_q;
  logic              rsp_cout_q;
  logic              rsp_err_q;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (reset),
    .req_i ({r1_valid, r0_valid}),
    .upd_i (acc),
    .gnt_o (gnt)
  );

  // Mux the granted request and classify its opcode.
  always_comb begin
    acc_id = gnt[1];
    sel_a  = acc_id ? r1_a  : r0_a;
    sel_b  = acc_id ? r1_b  : r0_b;
    sel_op = acc_id ? r1_op : r0_op;
    legal  = op_is_legal(sel_op, sel_b);
    divz   = op_is_divz(sel_op, sel_b);
    acc    = (r0_valid & r0_ready) | (r1_valid & r1_ready);
  end

  // Next state and ready outputs.
  always_comb begin
    state_d  = state_q;
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        r0_ready = gnt[0] & reset;
        r1_ready = gnt[1] & reset;
        if (acc) begin
          state_d = legal ? EXEC : RESP;
        end
      end
      EXEC:    state_d = WAIT;
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU operands load on a legal accept; response regs load on RESP entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_f_q    <= '0;
      rsp_cout_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (acc && legal) begin
        alu_a_q   <= sel_a;
        alu_b_q   <= sel_b;
        alu_sel_q <= sel_op;
        id_q      <= acc_id;
      end
      if (acc && !legal) begin
        rsp_id_q   <= acc_id;
        rsp_f_q    <= divz ? DIVZ_RESULT : ILLEGAL_RESULT;
        rsp_cout_q <= 1'b0;
        rsp_err_q  <= 1'b1;
      end
      if (state_q == WAIT) begin
        rsp_id_q   <= id_q;
        rsp_f_q    <= alu_f;
        rsp_cout_q <= alu_cout;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_err   = rsp_err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_sched.sv
// Testbench for alu_sched with a bench-side registered ALU.
// Vector table plus round-robin and reset-abort sequences.
module tb_alu_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       r0_valid, r1_valid;
  logic       r0_ready, r1_ready;
  logic [7:0] r0_a, r0_b, r1_a, r1_b;
  logic [3:0] r0_op, r1_op;
  logic       rsp_valid, rsp_id, rsp_cout, rsp_err;
  logic [7:0] rsp_f;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_f;
  logic       alu_cout;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_sched #(.DIVZ_RESULT(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0_valid  (r0_valid),
    .r1_valid  (r1_valid),
    .r0_ready  (r0_ready),
    .r1_ready  (r1_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r0_op     (r0_op),
    .r1_op     (r1_op),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f),
    .rsp_cout  (rsp_cout),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_f     (alu_f),
    .alu_cout  (alu_cout)
  );

  // Registered ALU: sub carry is borrow, mul carry is any high-byte bit.
  logic [15:0] prod;
  logic [8:0]  wide;
  always @(posedge clk) begin
    prod = alu_a * alu_b;
    case (alu_sel)
      4'd0: begin
        wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f <= wide[7:0]; alu_cout <= wide[8];
      end
      4'd1: begin
        wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_f <= wide[7:0]; alu_cout <= wide[8];
      end
      4'd2: begin
        alu_f <= prod[7:0]; alu_cout <= |prod[15:8];
      end
      4'd3: begin
        alu_f <= (alu_b == 0) ? 8'h00 : alu_a / alu_b;
        alu_cout <= 1'b0;
      end
      default: begin
        alu_f <= 8'h00; alu_cout <= 1'b0;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic       cout;
    logic       err;
    int         lat;
  } vec_t;

  // Issue one request from a single requester and check its response.
  task automatic run_vec(input vec_t v);
    int lat;
    logic [3:0] sel_before;
    logic [7:0] f_seen;
    bit got;
    @(negedge clk);
    sel_before = alu_sel;
    r0_valid = (v.id == 1'b0);
    r1_valid = (v.id == 1'b1);
    if (v.id) begin r1_a = v.a; r1_b = v.b; r1_op = v.op; end
    else      begin r0_a = v.a; r0_b = v.b; r0_op = v.op; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if ((v.id ? r1_ready : r0_ready) === 1'b1) got = 1;
      else @(negedge clk);
    end
    chk("ready_seen", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1;
    r0_valid = 0;
    r1_valid = 0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid === 1'b1) got = 1;
    end
    chk("rsp_seen", {31'd0, got}, 32'd1);
    chk("latency", lat, v.lat);
    chk("rsp_id", {31'd0, rsp_id}, {31'd0, v.id});
    chk("rsp_f", {24'd0, rsp_f}, {24'd0, v.f});
    chk("rsp_cout", {31'd0, rsp_cout}, {31'd0, v.cout});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.err});
    if (v.err) chk("alu_sel_held", {28'd0, alu_sel}, {28'd0, sel_before});
    else       chk("alu_sel_load", {28'd0, alu_sel}, {28'd0, v.op});
    f_seen = rsp_f;
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_f_stable", {24'd0, rsp_f}, {24'd0, f_seen});
  endtask

  vec_t vecs[12];
  int   n;
  logic [7:0] exp_f;

  initial begin
    vecs[0]  = '{1'b0, 4'd0, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0, 3};
    vecs[1]  = '{1'b1, 4'd1, 8'd9,   8'd4,   8'd5,   1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 4'd1, 8'd3,   8'd5,   8'hFE,  1'b1, 1'b0, 3};
    vecs[3]  = '{1'b1, 4'd2, 8'd5,   8'd6,   8'd30,  1'b0, 1'b0, 3};
    vecs[4]  = '{1'b0, 4'd2, 8'd20,  8'd20,  8'h90,  1'b1, 1'b0, 3};
    vecs[5]  = '{1'b1, 4'd3, 8'd7,   8'd0,   8'hFF,  1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 4'hA, 8'd1,   8'd2,   8'hAC,  1'b0, 1'b1, 1};
    vecs[7]  = '{1'b1, 4'd3, 8'd20,  8'd3,   8'd6,   1'b0, 1'b0, 3};
    vecs[8]  = '{1'b0, 4'd0, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0, 3};
    vecs[9]  = '{1'b0, 4'd3, 8'd255, 8'd255, 8'd1,   1'b0, 1'b0, 3};
    vecs[10] = '{1'b1, 4'd4, 8'd9,   8'd9,   8'hAC,  1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 4'hF, 8'd0,   8'd0,   8'hAC,  1'b0, 1'b1, 1};

    reset = 0;
    r0_valid = 1; r1_valid = 1;
    r0_a = 0; r0_b = 0; r0_op = 0;
    r1_a = 0; r1_b = 0; r1_op = 0;
    repeat (3) @(negedge clk);
    chk("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
    chk("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_outs", {rsp_id, rsp_cout, rsp_err, rsp_f, alu_a, alu_b,
                     alu_sel, 1'b0}, 32'd0);

    // Both requesters valid continuously: r0 first, then alternate.
    r0_a = 9; r0_b = 4; r0_op = 1;
    r1_a = 5; r1_b = 6; r1_op = 2;
    reset = 1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (r0_ready === 1'b1 || r1_ready === 1'b1)
        chk("ready_onehot", {31'd0, r0_ready & r1_ready}, 32'd0);
      if (rsp_valid === 1'b1) begin
        exp_f = n[0] ? 8'd30 : 8'd5;
        chk("rr_id", {31'd0, rsp_id}, {31'd0, n[0]});
        chk("rr_f", {24'd0, rsp_f}, {24'd0, exp_f});
        n++;
      end
    end
    chk("rr_count", n, 4);
    r0_valid = 0; r1_valid = 0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset while the op sits in WAIT: no response, outputs cleared.
    @(negedge clk);
    r0_valid = 1; r0_a = 8'd77; r0_b = 8'd1; r0_op = 4'd0;
    n = 0;
    while (r0_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("abort_ready", {31'd0, r0_ready}, 32'd1);
    @(posedge clk);
    #1;
    r0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_alu_a", {24'd0, alu_a}, 32'd77);
    reset = 0;
    #1;
    chk("abort_outs", {rsp_valid, rsp_id, rsp_cout, rsp_err, rsp_f, alu_a,
                       alu_b, alu_sel}, 32'd0);
    r0_valid = 1; r1_valid = 1;
    #1;
    chk("abort_rdy", {30'd0, r1_ready, r0_ready}, 32'd0);
    r0_valid = 0; r1_valid = 0;
    @(negedge clk);
    reset = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) n++;
    end
    chk("abort_no_rsp", n, 0);
    r0_valid = 1; r1_valid = 1;
    r0_op = 4'd0; r0_a = 1; r0_b = 1;
    r1_op = 4'd0; r1_a = 2; r1_b = 2;
    #1;
    chk("abort_gnt_r0", {30'd0, r1_ready, r0_ready}, 32'd1);
    @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
